zoran_nios_irq_aggregator: RTL and testbench
============================================

# zoran_nios_irq_aggregator

Interrupt aggregator that sits directly downstream of the Nios high-resolution and system timers: it consumes their `irq` outputs, plus other peripheral interrupt lines, and presents one masked interrupt to the CPU. Each source is synchronized and latched as level or rising-edge. The block exposes pending, mask, mode, raw, vector and software-force registers on the same 16-bit Avalon-MM slave style as the timers.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..16.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data. Reset value 0.
- `irq_in`  in  NUM_SRC  source interrupt lines, active-high, may be asynchronous.
- `irq_out`  out  1  registered aggregate interrupt to the CPU. Reset value 0.

## Operation
- Write strobe for address A: `chipselect && ~write_n && address==A`.
- Source path, per bit:
  - `irq_in` passes through a 2-flop synchronizer to give `sync`.
  - `prev` holds `sync` from the previous cycle.
  - `rise = sync & ~prev`.
- Register map (bits at and above NUM_SRC read 0 and ignore writes):
  - 0 STATUS: pending bits. Writing 1 to a bit clears it, for edge-mode sources only.
  - 1 MASK: enable bits. R/W. Reset 0.
  - 2 MODE: 1 = edge, 0 = level. R/W. Reset 0.
  - 3 RAW: `sync`. Read-only.
  - 4 VECTOR: bit15 = valid; bits[3:0] = lowest index with `pending & mask` set. Read-only.
  - 5 FORCE: writing 1 sets pending for edge-mode sources. Reads 0.
  - 6, 7: read 0; writes ignored.
- Pending update, each cycle:
  - Level source: `pending <= sync`. STATUS and FORCE writes have no effect.
  - Edge source: set if `rise` or FORCE bit written; cleared if STATUS bit written. A set in the same cycle as a clear wins, so no event is lost.
  - MODE write: every source whose mode bit changes has its pending bit cleared that cycle. The new mode applies from the next cycle.
- `irq_out <= |(pending & mask)`.
- Reads: `readdata <= mux(address)` every cycle, regardless of `chipselect`, matching the timer slave. All registers reset to 0, including the synchronizer and `prev`.

## Timing
- Read latency: 1 cycle. `readdata` is valid on the clock after the address is presented.
- Write latency:
  - Register writes take effect at the write clock edge.
  - `irq_out` reflects a MASK, STATUS or FORCE change 1 cycle later.
- Source to `irq_out`, with `irq_in` rising before edge 0:
  - `sync` high after edge 1.
  - `pending` high after edge 2.
  - `irq_out` high after edge 3.
  - This holds for both modes.
- Level source deasserting: `irq_out` falls 3 edges after `irq_in` falls, provided no other source is active.
- Edge source held high continuously gives one event only. A new event requires `irq_in` low for at least 2 cycles.
- Reset asserted mid-operation clears everything asynchronously; `irq_out` drops immediately. After release, a source already high is seen as a rise and latches in edge mode.

## Configuration
- `IRQ_AGG_VECTOR_EN`:
  - Defined: the priority encoder and the VECTOR register (address 4) are built. VECTOR is computed combinationally from registered `pending & mask` and registered through `readdata`.
  - Undefined: no encoder logic; address 4 reads 0 (valid = 0).
  - All other behaviour is identical in both builds.

## Structure
- Package `zoran_nios_irq_pkg`:
  - Register address constants `IRQ_ADDR_STATUS` .. `IRQ_ADDR_FORCE`.
  - VECTOR field positions: `IRQ_VEC_VALID_BIT = 15`, index width 4.
  - `IRQ_MAX_SRC = 16`.
- Sub-module `zoran_nios_irq_sync_edge`: NUM_SRC-wide 2-flop synchronizer, `prev` register and `rise` output. It is instantiated once.
- Top level holds the pending/mask/mode registers, the read mux and the optional encoder.

## Test plan
- Reset, then read all 8 addresses: every one returns 0x0000; `irq_out` = 0.
- MASK = 0x0001, MODE = 0; raise `irq_in[0]` → `irq_out` = 1 exactly 3 edges later. Drop `irq_in[0]` → `irq_out` = 0 3 edges later. STATUS write 0x0001 during assertion has no effect.
- MODE = 0x0004, MASK = 0x0004; pulse `irq_in[2]` for 2 cycles → STATUS reads 0x0004 and `irq_out` stays 1. Write STATUS = 0x0004 → `irq_out` = 0 one cycle later.
- Edge source 2: schedule a STATUS clear of bit 2 in the same cycle as a new `rise` on source 2 → STATUS still reads 0x0004.
- MODE = 0x00FF, MASK = 0x0060; write FORCE = 0x0060 → `irq_out` = 1; VECTOR reads 0x8005. Clear bit 5 → VECTOR = 0x8006. Without `IRQ_AGG_VECTOR_EN`, VECTOR reads 0x0000.
- Edge source 1 pending; write MODE toggling bit 1 → pending bit 1 cleared. Assert `reset_n` low mid-pulse → `irq_out` falls asynchronously.

Source files
------------

// File: rtl/zoran_nios_irq_pkg.sv
// Shared constants for the Nios interrupt aggregator: register word addresses,
// VECTOR field layout and the source-count limit.
package zoran_nios_irq_pkg;

  localparam int unsigned IRQ_MAX_SRC = 16;
  localparam int unsigned IRQ_DATA_W  = 16;
  localparam int unsigned IRQ_ADDR_W  = 3;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_STATUS = 3'd0;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MASK   = 3'd1;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MODE   = 3'd2;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_RAW    = 3'd3;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_VECTOR = 3'd4;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_FORCE  = 3'd5;

  localparam int unsigned IRQ_VEC_VALID_BIT = 15;
  localparam int unsigned IRQ_VEC_IDX_W     = 4;

endpackage

// File: rtl/zoran_nios_irq_aggregator_if.sv
// 16-bit Avalon-MM style slave bus used by the interrupt aggregator.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : registered read data (driven by the slave)
interface zoran_nios_irq_aggregator_if;
  import zoran_nios_irq_pkg::*;

  logic [IRQ_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [IRQ_DATA_W-1:0] writedata;
  logic [IRQ_DATA_W-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/zoran_nios_irq_sync_edge.sv
// Per-source 2-flop synchronizer plus a one-cycle history register for rising
// edge detection.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   irq_i  : raw (possibly asynchronous) interrupt lines
//   sync_o : synchronized lines
//   rise_o : synchronized rising-edge pulse, one cycle wide
module zoran_nios_irq_sync_edge #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic [NUM_SRC-1:0] sync_o,
  output logic [NUM_SRC-1:0] rise_o
);

  logic [NUM_SRC-1:0] meta_q;
  logic [NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/zoran_nios_irq_aggregator.sv
// Interrupt aggregator: synchronizes NUM_SRC interrupt lines, latches each as
// level or rising-edge, and drives one masked, registered interrupt to the CPU.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : 16-bit register slave (STATUS, MASK, MODE, RAW, VECTOR, FORCE)
//   irq_in   : source interrupt lines, active-high
//   irq_out  : registered aggregate interrupt
// Build option: define IRQ_AGG_VECTOR_EN to build the priority encoder behind
// the VECTOR register; otherwise VECTOR reads 0.
module zoran_nios_irq_aggregator
  import zoran_nios_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  zoran_nios_irq_aggregator_if.slave  bus,
  input  logic [NUM_SRC-1:0]          irq_in,
  output logic                        irq_out
);

  logic [NUM_SRC-1:0] sync, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wdata, set_edge, clr_edge, mode_chg;
  logic [IRQ_DATA_W-1:0] readdata_q, rdata_d;
  logic irq_out_q;
  logic wr_en, wr_status, wr_mask, wr_mode, wr_force;
  logic unused_wdata;

  zoran_nios_irq_sync_edge #(
    .NUM_SRC (NUM_SRC)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .irq_i  (irq_in),
    .sync_o (sync),
    .rise_o (rise)
  );

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_status = wr_en && (bus.address == IRQ_ADDR_STATUS);
  assign wr_mask   = wr_en && (bus.address == IRQ_ADDR_MASK);
  assign wr_mode   = wr_en && (bus.address == IRQ_ADDR_MODE);
  assign wr_force  = wr_en && (bus.address == IRQ_ADDR_FORCE);
  assign wdata     = bus.writedata[NUM_SRC-1:0];
  // Upper data bits are ignored when NUM_SRC < 16.
  assign unused_wdata = ^bus.writedata;

  assign active = pending_q & mask_q;

  always_comb begin
    set_edge = rise | (wr_force ? wdata : '0);
    clr_edge = wr_status ? wdata : '0;
    mode_chg = wr_mode ? (wdata ^ mode_q) : '0;
    // Edge sources: a set beats a same-cycle clear so no event is lost.
    pending_d = (mode_q & (set_edge | (pending_q & ~clr_edge))) | (~mode_q & sync);
    // A mode change discards the pending bit; the new mode applies next cycle.
    pending_d = pending_d & ~mode_chg;
    mask_d    = wr_mask ? wdata : mask_q;
    mode_d    = wr_mode ? wdata : mode_q;
  end

`ifdef IRQ_AGG_VECTOR_EN
  logic [IRQ_VEC_IDX_W-1:0] vec_idx;
  logic [IRQ_DATA_W-1:0]    vec_word;

  // Scan downward so the lowest active index wins.
  always_comb begin
    vec_idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = IRQ_VEC_IDX_W'(i);
    end
    vec_word = '0;
    vec_word[IRQ_VEC_VALID_BIT] = |active;
    vec_word[IRQ_VEC_IDX_W-1:0] = vec_idx;
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      IRQ_ADDR_STATUS: rdata_d[NUM_SRC-1:0] = pending_q;
      IRQ_ADDR_MASK:   rdata_d[NUM_SRC-1:0] = mask_q;
      IRQ_ADDR_MODE:   rdata_d[NUM_SRC-1:0] = mode_q;
      IRQ_ADDR_RAW:    rdata_d[NUM_SRC-1:0] = sync;
      IRQ_ADDR_VECTOR: begin
`ifdef IRQ_AGG_VECTOR_EN
        rdata_d = vec_word;
`endif
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      irq_out_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      irq_out_q  <= |active;
      readdata_q <= rdata_d;
    end
  end

  assign irq_out      = irq_out_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_zoran_nios_irq_aggregator.sv
module tb_zoran_nios_irq_aggregator;
  import zoran_nios_irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       irq_out;
  logic [15:0] rd;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  zoran_nios_irq_aggregator_if bus_if ();

  zoran_nios_irq_aggregator #(
    .NUM_SRC (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

`ifdef IRQ_AGG_VECTOR_EN
  localparam logic [15:0] ExpVec5 = 16'h8005;
  localparam logic [15:0] ExpVec6 = 16'h8006;
`else
  localparam logic [15:0] ExpVec5 = 16'h0000;
  localparam logic [15:0] ExpVec6 = 16'h0000;
`endif

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [15:0] data);
    bus_if.address = addr;
    tick();
    data = bus_if.readdata;
  endtask

  initial begin
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state of every address.
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check_eq($sformatf("reset_rd%0d", a), rd, 16'h0000);
    end
    check_eq("reset_irq", {15'b0, irq_out}, 16'h0000);

    // Level source 0.
    bus_write(IRQ_ADDR_MASK, 16'h0001);
    irq_in = 8'h01;
    repeat (3) tick();
    check_eq("lvl_rise_e2", {15'b0, irq_out}, 16'h0000);
    tick();
    check_eq("lvl_rise_e3", {15'b0, irq_out}, 16'h0001);
    bus_write(IRQ_ADDR_STATUS, 16'h0001);
    check_eq("lvl_status_wr_irq", {15'b0, irq_out}, 16'h0001);
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("lvl_status_rd", rd, 16'h0001);
    bus_read(IRQ_ADDR_RAW, rd);
    check_eq("raw_rd", rd, 16'h0001);
    irq_in = 8'h00;
    repeat (3) tick();
    check_eq("lvl_fall_e2", {15'b0, irq_out}, 16'h0001);
    tick();
    check_eq("lvl_fall_e3", {15'b0, irq_out}, 16'h0000);

    // Edge source 2, short pulse.
    bus_write(IRQ_ADDR_MODE, 16'h0004);
    bus_write(IRQ_ADDR_MASK, 16'h0004);
    irq_in = 8'h04;
    repeat (2) tick();
    irq_in = 8'h00;
    repeat (4) tick();
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("edge_status_rd", rd, 16'h0004);
    check_eq("edge_irq_held", {15'b0, irq_out}, 16'h0001);
    bus_write(IRQ_ADDR_STATUS, 16'h0004);
    check_eq("edge_clr_irq_same", {15'b0, irq_out}, 16'h0001);
    tick();
    check_eq("edge_clr_irq_next", {15'b0, irq_out}, 16'h0000);

    // Clear in the same cycle as a new rise: the set wins.
    irq_in = 8'h04;
    repeat (2) tick();
    bus_write(IRQ_ADDR_STATUS, 16'h0004);
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("set_beats_clr", rd, 16'h0004);
    irq_in = 8'h00;
    bus_write(IRQ_ADDR_STATUS, 16'h0004);
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("edge_cleared", rd, 16'h0000);

    // FORCE and VECTOR.
    bus_write(IRQ_ADDR_MODE, 16'h00FF);
    bus_write(IRQ_ADDR_MASK, 16'h0060);
    bus_write(IRQ_ADDR_FORCE, 16'h0060);
    check_eq("force_irq_same", {15'b0, irq_out}, 16'h0000);
    tick();
    check_eq("force_irq_next", {15'b0, irq_out}, 16'h0001);
    bus_read(IRQ_ADDR_VECTOR, rd);
    check_eq("vector_5", rd, ExpVec5);
    bus_write(IRQ_ADDR_STATUS, 16'h0020);
    bus_read(IRQ_ADDR_VECTOR, rd);
    check_eq("vector_6", rd, ExpVec6);
    bus_read(IRQ_ADDR_FORCE, rd);
    check_eq("force_rd0", rd, 16'h0000);
    bus_read(IRQ_ADDR_MODE, rd);
    check_eq("mode_rd", rd, 16'h00FF);

    // Mode toggle clears pending.
    bus_write(IRQ_ADDR_FORCE, 16'h0002);
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("force_bit1", rd, 16'h0042);
    bus_write(IRQ_ADDR_MODE, 16'h00FD);
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("mode_chg_clr", rd, 16'h0040);
    check_eq("pre_reset_irq", {15'b0, irq_out}, 16'h0001);

    // Asynchronous reset mid-pulse.
    irq_in = 8'h08;
    tick();
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_irq", {15'b0, irq_out}, 16'h0000);
    check_eq("async_rst_rdata", bus_if.readdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(IRQ_ADDR_MASK, rd);
    check_eq("post_rst_mask", rd, 16'h0000);
    bus_read(IRQ_ADDR_MODE, rd);
    check_eq("post_rst_mode", rd, 16'h0000);
    repeat (3) tick();
    bus_read(IRQ_ADDR_STATUS, rd);
    check_eq("post_rst_level", rd, 16'h0008);
    check_eq("post_rst_irq", {15'b0, irq_out}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
